uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte hand-off between the transmit FIFO and the UART transmitter.
//
// Handshake: the FIFO raises `valid` while `din` holds a byte. The transmitter
// samples the pair only at its capture points: in IDLE, or at the final edge of
// a stop bit. A byte counts as transferred on the edge where it is sampled with
// `valid`=1. The transmitter then drives `data_accepted` high for exactly the
// following cycle. The FIFO advances `din` at the edge that ends that pulse.
// The transmitter does not look at `valid`/`din` while the pulse is high.
interface uart_tx_if;
  logic       valid;
  logic [7:0] din;
  logic       data_accepted;

  // FIFO side
  modport master (
    output valid,
    output din,
    input  data_accepted
  );

  // Transmitter side
  modport slave (
    input  valid,
    input  din,
    output data_accepted
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with optional even parity. It drains bytes from the
// upstream FIFO through uart_tx_if. Frames follow back to back while the FIFO
// stays non-empty.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy,
  output logic [2:0] o_state_dbg
);

  localparam int            BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_sh;
  logic [BW-1:0] r_bcnt;
  logic [2:0]    r_bidx;
  logic          r_par;
  logic          r_tx;
  logic          r_busy;
  logic          r_acc;
  logic          w_bit_end;

  // Last clock cycle of the current serial bit.
  assign w_bit_end = (r_bcnt == BLAST);

  assign tx                = r_tx;
  assign busy              = r_busy;
  assign bus.data_accepted = r_acc;
  assign o_state_dbg       = r_state;

  // Frame sequencer. All outputs are registered. A capture loads the byte and
  // drives the start bit in the same edge, so the start bit and the accept
  // pulse appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= 8'h00;
      r_bcnt  <= '0;
      r_bidx  <= 3'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_acc   <= 1'b0;
    end else begin
      r_acc <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (bus.valid) begin
            r_sh    <= bus.din;
            r_par   <= ^bus.din;
            r_acc   <= 1'b1;
            r_bcnt  <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bcnt  <= '0;
            r_bidx  <= 3'd0;
            r_tx    <= r_sh[0];
            r_state <= DATA;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_bcnt <= '0;
            r_sh   <= r_sh >> 1;
            if (r_bidx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bidx <= r_bidx + 3'd1;
              r_tx   <= r_sh[1];
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_bcnt  <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_bcnt <= '0;
            // A waiting byte starts the next frame with no idle gap.
            if (bus.valid) begin
              r_sh    <= bus.din;
              r_par   <= ^bus.din;
              r_acc   <= 1'b1;
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_bcnt  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. It uses two instances at 4 clocks per bit: one
// without parity and one with parity. A FIFO model feeds each instance.
// Bytes loaded into a FIFO are also queued as expected frames, and each
// transmitted frame is checked bit by bit against the next queued byte.
module tb_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx0, busy0, tx1, busy1;
  logic [2:0] st0, st1;

  // Clock generation.
  always #5 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .tx(tx0), .busy(busy0), .o_state_dbg(st0)
  );
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .tx(tx1), .busy(busy1), .o_state_dbg(st1)
  );

  int         checks   = 0;
  int         failures = 0;
  int         pulses0  = 0;
  int         pulses1  = 0;
  logic [7:0] fifo0[$];
  logic [7:0] fifo1[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The FIFO model presents its head byte whenever it is non-empty.
  task automatic drive();
    if0.valid = (fifo0.size() > 0);
    if0.din   = (fifo0.size() > 0) ? fifo0[0] : 8'h00;
    if1.valid = (fifo1.size() > 0);
    if1.din   = (fifo1.size() > 0) ? fifo1[0] : 8'h00;
  endtask

  // Advance one clock. Sampling happens 1 time unit after the rising edge.
  // A FIFO pops at the edge that ends an accept pulse.
  task automatic tick();
    logic a0, a1;
    a0 = if0.data_accepted;
    a1 = if1.data_accepted;
    @(posedge clk);
    #1;
    if (a0 && fifo0.size() > 0) void'(fifo0.pop_front());
    if (a1 && fifo1.size() > 0) void'(fifo1.pop_front());
    if (if0.data_accepted === 1'b1) pulses0++;
    if (if1.data_accepted === 1'b1) pulses1++;
    drive();
  endtask

  task automatic load(input int sel, input logic [7:0] b);
    if (sel == 0) fifo0.push_back(b);
    else          fifo1.push_back(b);
    exp_q.push_back(b);
    drive();
  endtask

  // Called in the first cycle of a frame. Each bit must hold for exactly CPB
  // cycles. The task returns in the cycle right after the stop bit.
  task automatic frame_check(input int sel, input string tag);
    logic [7:0]  b;
    logic [10:0] bits;
    int          nb;
    logic        ok;
    logic        ok_busy;
    if (exp_q.size() == 0) begin
      chk({tag, "_expq_nonempty"}, 0, 1);
      return;
    end
    b = exp_q.pop_front();
    chk({tag, "_pulse"}, (sel != 0) ? if1.data_accepted : if0.data_accepted, 1);
    bits    = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    if (sel != 0) begin
      nb       = 11;
      bits[9]  = ^b;
      bits[10] = 1'b1;
    end else begin
      nb      = 10;
      bits[9] = 1'b1;
    end
    ok_busy = 1'b1;
    for (int k = 0; k < nb; k++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (((sel != 0) ? tx1 : tx0) !== bits[k]) ok = 1'b0;
        if (((sel != 0) ? busy1 : busy0) !== 1'b1) ok_busy = 1'b0;
        tick();
      end
      chk($sformatf("%s_bit%0d_b%02h", tag, k, b), ok, 1);
    end
    chk({tag, "_busy_frame"}, ok_busy, 1);
  endtask

  initial begin
    int   p;
    logic ok;
    rst = 1'b1;
    drive();

    // Reset held with a byte already waiting.
    load(0, 8'h55);
    repeat (3) tick();
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_acc", if0.data_accepted, 0);
    chk("rst_state", st0, 0);
    chk("rst_tx_par", tx1, 1);
    chk("rst_no_pulse", pulses0, 0);
    rst = 1'b0;
    tick();
    chk("rst_first_start", tx0, 0);
    frame_check(0, "rst_frame");
    chk("rst_frame_idle_busy", busy0, 0);
    chk("rst_frame_pulses", pulses0, 1);

    // Single byte 0xA5.
    p = pulses0;
    load(0, 8'hA5);
    tick();
    chk("a5_busy_start", busy0, 1);
    frame_check(0, "a5");
    chk("a5_busy_after", busy0, 0);
    chk("a5_tx_idle", tx0, 1);
    chk("a5_pulses", pulses0 - p, 1);

    // Three frames back to back with no idle gap.
    p = pulses0;
    load(0, 8'h00);
    load(0, 8'hFF);
    load(0, 8'h3C);
    tick();
    frame_check(0, "b2b0");
    frame_check(0, "b2b1");
    frame_check(0, "b2b2");
    chk("b2b_busy_after", busy0, 0);
    chk("b2b_fifo_empty", fifo0.size(), 0);
    chk("b2b_pulses", pulses0 - p, 3);

    // Even parity: 0x07 gives parity bit 1, 0x03 gives parity bit 0.
    p = pulses1;
    load(1, 8'h07);
    tick();
    frame_check(1, "par07");
    chk("par07_busy_after", busy1, 0);
    load(1, 8'h03);
    tick();
    frame_check(1, "par03");
    chk("par03_busy_after", busy1, 0);
    chk("par_pulses", pulses1 - p, 2);

    // Reset asserted during D3 of 0x5A.
    p = pulses0;
    load(0, 8'h5A);
    tick();
    chk("mid_acc", if0.data_accepted, 1);
    repeat (17) tick();
    chk("mid_state_data", st0, 2);
    rst = 1'b1;
    #1;
    chk("mid_async_tx", tx0, 1);
    chk("mid_async_busy", busy0, 0);
    chk("mid_async_state", st0, 0);
    void'(exp_q.pop_front());
    load(0, 8'h11);
    repeat (3) tick();
    chk("mid_no_pulse_in_rst", pulses0 - p, 1);
    chk("mid_acc_in_rst", if0.data_accepted, 0);
    rst = 1'b0;
    tick();
    frame_check(0, "post_rst");
    chk("post_rst_busy", busy0, 0);
    chk("post_rst_pulses", pulses0 - p, 2);

    // Stall: 100 idle cycles, then a new byte.
    p  = pulses0;
    ok = 1'b1;
    repeat (100) begin
      tick();
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.data_accepted !== 1'b0) ok = 1'b0;
    end
    chk("stall_quiet", ok, 1);
    chk("stall_pulses", pulses0 - p, 0);
    load(0, 8'h96);
    tick();
    chk("stall_wake_tx", tx0, 0);
    chk("stall_wake_busy", busy0, 1);
    frame_check(0, "stall_frame");
    chk("stall_frame_busy", busy0, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
